mem_responder: RTL



---
 rtl/mem_responder_pkg.sv | 26 ++
 rtl/mem_responder_if.sv | 22 ++
 rtl/mem_responder_sram.sv | 34 +++
 rtl/mem_responder.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder and its storage array.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    MR_IDLE    = 2'd0,
    MR_CAPTURE = 2'd1,
    MR_WAIT    = 2'd2,
    MR_RESPOND = 2'd3
  } memresp_state_t;

  typedef enum logic [1:0] {
    MEM_OP_READ  = 2'd0,
    MEM_OP_WRITE = 2'd1,
    MEM_OP_BAD   = 2'd2
  } mem_op_t;

  localparam int WORD_BYTES = 4;

  // Both strobes together is a protocol error and is never turned into an access.
  function automatic mem_op_t decode_op(input logic rd, input logic wr);
    if (rd && wr) return MEM_OP_BAD;
    else if (wr)  return MEM_OP_WRITE;
    else          return MEM_OP_READ;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-side single-outstanding memory bus: strobes, MAR/MDR/mask in, data/resp/err/busy out.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic        busy;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata, mem_resp, mem_err, busy
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata, mem_resp, mem_err, busy
  );
endinterface

// File: rtl/mem_responder_sram.sv
// Single-port word array with synchronous read and per-byte write enables.
module mem_sram #(
  parameter int  DEPTH_WORDS = 4096,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wmask_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the array has no reset on purpose: it must map onto a RAM macro, and
  // its contents survive rst.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE -> CAPTURE -> WAIT x LATENCY -> RESPOND, one request at a time.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE    = MR_IDLE;
  localparam logic [1:0] S_CAPTURE = MR_CAPTURE;
  localparam logic [1:0] S_WAIT    = MR_WAIT;
  localparam logic [1:0] S_RESPOND = MR_RESPOND;

  logic [1:0]    state_q, state_d;
  mem_op_t       op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          oob_q, oob_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0] offset;
  logic        oob;
  logic        sram_en;
  logic [31:0] sram_rdata;
  logic [31:0] rdata_now;

  // Offset wraps below BASE_ADDR, so the explicit compare catches that case.
  assign offset = bus.mem_addr - BASE_ADDR;
  assign oob    = (bus.mem_addr < BASE_ADDR) ||
                  ((offset >> $clog2(WORD_BYTES)) >= 32'(DEPTH_WORDS));

  assign sram_en   = (state_q == S_WAIT) && (cnt_q == '0) && !oob_q && (op_q != MEM_OP_BAD);
  assign rdata_now = (state_q == S_RESPOND && op_q == MEM_OP_READ)
                   ? (oob_q ? 32'h0 : sram_rdata) : rdata_q;

  // NOTE: every next-state signal gets its default first, so no latches are
  // inferred; state changes only in the always_ff below, with <=.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    oob_d   = oob_q;
    err_d   = err_q;
    rdata_d = rdata_now;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          op_d    = decode_op(bus.mem_read, bus.mem_write);
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        idx_d   = offset[AW+1:2];
        wdata_d = bus.mem_wdata;
        wmask_d = bus.mem_wmask;
        oob_d   = oob;
        err_d   = oob || (bus.mem_addr[1:0] != 2'b00) || (op_q == MEM_OP_BAD);
        cnt_d   = CW'(LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESPOND;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MEM_OP_READ;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      oob_q   <= oob_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  mem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk     (clk),
    .en_i    (sram_en),
    .we_i    (op_q == MEM_OP_WRITE),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .wmask_i (wmask_q),
    .rdata_o (sram_rdata)
  );

  assign bus.mem_rdata = rdata_now;
  assign bus.mem_resp  = (state_q == S_RESPOND);
  assign bus.mem_err   = (state_q == S_RESPOND) && err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule
